modular_addsub_arbiter: RTL and testbench

//  Shares one modular add/subtract datapath (mod M) among N_REQ requesters in the
//  mm subsystem, e.g. butterfly and reduction stages.

---
 rtl/mm_pkg.sv | 18 +
 rtl/modular_addsub_unit.sv | 37 +++
 rtl/modular_addsub_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_modular_addsub_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the modular-arithmetic (mm) blocks.
//   mm_op_e        : operation select (add / subtract mod M)
//   MM_MOD_DEFAULT : default 64-bit modulus 2^64 - 2^32 + 1
//   id_width()     : width of a requester index for n requesters
package mm_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } mm_op_e;

    localparam logic [63:0] MM_MOD_DEFAULT = 64'hFFFF_FFFF_0000_0001;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/modular_addsub_unit.sv
// Combinational modular adder/subtractor.
// Operands must already be reduced (x, y < M); the result is then in [0, M).
//   x, y : operands
//   op   : OP_ADD -> (x + y) mod M, OP_SUB -> (x - y) mod M
//   z    : result
module modular_addsub_unit
    import mm_pkg::*;
#(
    parameter int                    data_width = 64,
    parameter logic [data_width-1:0] M          = data_width'(MM_MOD_DEFAULT)
) (
    input  logic [data_width-1:0] x,
    input  logic [data_width-1:0] y,
    input  logic                  op,
    output logic [data_width-1:0] z
);

    logic [data_width:0] sum;
    logic [data_width:0] sum_red;
    logic [data_width:0] diff;
    logic [data_width-1:0] diff_wrap;

    always_comb begin
        sum       = {1'b0, x} + {1'b0, y};
        sum_red   = sum - {1'b0, M};
        diff      = {1'b0, x} - {1'b0, y};
        // a borrow means x < y, so adding M back lands in [0, M)
        diff_wrap = diff[data_width-1:0] + M;

        if (op == OP_SUB) begin
            z = diff[data_width] ? diff_wrap : diff[data_width-1:0];
        end else begin
            z = (sum >= {1'b0, M}) ? sum_red[data_width-1:0] : sum[data_width-1:0];
        end
    end

endmodule

// File: rtl/modular_addsub_arbiter.sv
// Round-robin arbiter sharing one modular add/sub datapath among N_REQ requesters.
// One operation is accepted per cycle; results leave on a single tagged response port.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester operation valid
//   req_ready  : per-requester accept (one-hot or zero)
//   req_op     : per-requester op (OP_ADD / OP_SUB)
//   req_x/y    : packed operands, requester i at [i*data_width +: data_width]
//   rsp_valid  : result valid
//   rsp_ready  : downstream accept
//   rsp_data   : result in [0, M)
//   rsp_id     : index of the requester that issued the op
// Build option: define MODARB_PIPE_EN to insert an operand register stage between
// grant and arithmetic (latency 2 instead of 1, still one op per cycle).
module modular_addsub_arbiter
    import mm_pkg::*;
#(
    parameter int                    data_width = 64,
    parameter logic [data_width-1:0] M          = data_width'(MM_MOD_DEFAULT),
    parameter int                    N_REQ      = 4,
    localparam int                   ID_W       = id_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_op,
    input  logic [N_REQ*data_width-1:0] req_x,
    input  logic [N_REQ*data_width-1:0] req_y,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [data_width-1:0]       rsp_data,
    output logic [ID_W-1:0]             rsp_id
);

    localparam logic [ID_W-1:0] PTR_RESET = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [data_width-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic                  stage_ready;
    logic                  accept;
    logic [data_width-1:0] x_sel, y_sel;
    logic                  op_sel;
    logic [data_width-1:0] unit_x, unit_y, unit_z;
    logic                  unit_op;

    // Cyclic search starting one past the last granted requester.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % N_REQ;
            cand_idx = ID_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        x_sel  = req_x[int'(grant_idx)*data_width +: data_width];
        y_sel  = req_y[int'(grant_idx)*data_width +: data_width];
        op_sel = req_op[grant_idx];
    end

    assign stage_ready = !rsp_valid_q || rsp_ready;

`ifdef MODARB_PIPE_EN
    logic                  s1_valid_q, s1_valid_d;
    logic [data_width-1:0] s1_x_q, s1_x_d;
    logic [data_width-1:0] s1_y_q, s1_y_d;
    logic                  s1_op_q, s1_op_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic                  s1_ready;

    assign s1_ready = !s1_valid_q || stage_ready;
    assign accept   = s1_ready && grant_found;
    assign unit_x   = s1_x_q;
    assign unit_y   = s1_y_q;
    assign unit_op  = s1_op_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_op_d    = s1_op_q;
        s1_id_d    = s1_id_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_x_d     = x_sel;
            s1_y_d     = y_sel;
            s1_op_d    = op_sel;
            s1_id_d    = grant_idx;
        end else if (stage_ready) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (stage_ready) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = unit_z;
                rsp_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_op_q    <= 1'b0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_op_q    <= s1_op_d;
            s1_id_q    <= s1_id_d;
        end
    end
`else
    assign accept  = stage_ready && grant_found;
    assign unit_x  = x_sel;
    assign unit_y  = y_sel;
    assign unit_op = op_sel;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (stage_ready) begin
            rsp_valid_d = accept;
            if (accept) begin
                rsp_data_d = unit_z;
                rsp_id_d   = grant_idx;
            end
        end
    end
`endif

    modular_addsub_unit #(
        .data_width (data_width),
        .M          (M)
    ) u_unit (
        .x  (unit_x),
        .y  (unit_y),
        .op (unit_op),
        .z  (unit_z)
    );

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_d = accept ? grant_idx : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= PTR_RESET;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_modular_addsub_arbiter.sv
module tb_modular_addsub_arbiter;

    localparam int          N   = 4;
    localparam int          DW  = 64;
    localparam logic [63:0] MOD = 64'hFFFF_FFFF_0000_0001;
`ifdef MODARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_op;
    logic [N*DW-1:0]   req_x;
    logic [N*DW-1:0]   req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        rsp_id;

    modular_addsub_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic          drv_op [N];
    logic [63:0]   drv_x  [N];
    logic [63:0]   drv_y  [N];

    // reference model: rotating priority pointer plus an in-order queue of results,
    // each visible LAT cycles after acceptance; at most LAT ops are held at once
    typedef struct {
        logic [63:0] data;
        int          id;
        int          t;
    } item_t;
    item_t q[$];
    int    m_ptr = N - 1;
    int    now   = 0;

    logic [N-1:0] cap_rdy;
    logic         cap_rv;
    logic [63:0]  cap_rd;
    logic [1:0]   cap_rid;

    typedef struct {
        int          id;
        logic        op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic op, input logic [63:0] x, input logic [63:0] y);
        logic [64:0] r;
        if (!op) r = ({1'b0, x} + {1'b0, y}) % {1'b0, MOD};
        else     r = ({1'b0, x} + {1'b0, MOD} - {1'b0, y}) % {1'b0, MOD};
        return r[63:0];
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = MOD - 64'd1;
            2: v = 64'd1;
            default: begin
                v = {$urandom, $urandom};
                v = v % MOD;
            end
        endcase
        return v;
    endfunction

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            drv_op[i] = 1'($urandom_range(0, 1));
            drv_x[i]  = rnd_operand();
            drv_y[i]  = rnd_operand();
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = N - 1;
    endtask

    // one clock cycle: drive, check against the model, advance the model, clock
    task automatic cycle(input logic [N-1:0] v, input logic rr);
        logic [N-1:0] exp_rdy;
        bit hv, pop, acc;
        int g, occ;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_op[i]          = drv_op[i];
            req_x[i*DW +: DW]  = drv_x[i];
            req_y[i*DW +: DW]  = drv_y[i];
        end
        #1;
        cap_rdy = req_ready;
        cap_rv  = rsp_valid;
        cap_rd  = rsp_data;
        cap_rid = rsp_id;

        hv  = (q.size() > 0) && (q[0].t <= now);
        pop = hv && rr;
        occ = q.size() - (pop ? 1 : 0);
        g   = -1;
        for (int k = 1; k <= N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        acc     = (g >= 0) && (occ < LAT);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;

        chk("req_ready", 64'(cap_rdy), 64'(exp_rdy));
        chk("rsp_valid", 64'(cap_rv), 64'(hv));
        if (hv) begin
            chk("rsp_data", cap_rd, q[0].data);
            chk("rsp_id", 64'(cap_rid), 64'(q[0].id));
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{ref_op(drv_op[g], drv_x[g], drv_y[g]), g, now + LAT});
            m_ptr = g;
        end
        @(posedge clk);
        now++;
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] hold_d;
    logic [1:0]  hold_id;

    initial begin
        req_op = '0;
        req_x  = '0;
        req_y  = '0;
        for (int i = 0; i < N; i++) begin
            drv_op[i] = 1'b0;
            drv_x[i]  = '0;
            drv_y[i]  = '0;
        end

        vecs[0] = '{0, 1'b1, 64'd5,        64'd7,        64'hFFFF_FFFE_FFFF_FFFF};
        vecs[1] = '{2, 1'b0, MOD - 64'd1,  64'd2,        64'd1};
        vecs[2] = '{2, 1'b0, 64'd3,        64'd4,        64'd7};
        vecs[3] = '{2, 1'b1, 64'd9,        64'd9,        64'd0};
        vecs[4] = '{1, 1'b0, MOD - 64'd1,  64'd1,        64'd0};
        vecs[5] = '{3, 1'b0, MOD - 64'd1,  MOD - 64'd1,  64'hFFFF_FFFE_FFFF_FFFF};
        vecs[6] = '{1, 1'b1, 64'd0,        64'd1,        64'hFFFF_FFFF_0000_0000};
        vecs[7] = '{3, 1'b1, MOD - 64'd1,  64'd0,        64'hFFFF_FFFF_0000_0000};
        vecs[8] = '{0, 1'b0, 64'd0,        64'd0,        64'd0};
        vecs[9] = '{0, 1'b1, 64'd1,        MOD - 64'd1,  64'd2};

        do_reset();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);

        // directed arithmetic vectors, one requester at a time
        for (int i = 0; i < 10; i++) begin
            drv_op[vecs[i].id] = vecs[i].op;
            drv_x[vecs[i].id]  = vecs[i].x;
            drv_y[vecs[i].id]  = vecs[i].y;
            cycle(N'(1 << vecs[i].id), 1'b1);
            repeat (LAT - 1) cycle('0, 1'b1);
            chk("vec_valid", 64'(rsp_valid), 64'd1);
            chk("vec_data", rsp_data, vecs[i].z);
            chk("vec_id", 64'(rsp_id), 64'(vecs[i].id));
            cycle('0, 1'b1);
        end

        // all requesters valid: grants and results rotate 0,1,2,3,...
        do_reset();
        for (int k = 0; k < 8 + LAT; k++) begin
            rnd_ops();
            cycle((k < 8) ? 4'hF : 4'h0, 1'b1);
            if (k < 8) begin
                chk("rot_onehot", 64'($countones(cap_rdy)), 64'd1);
                chk("rot_grant", 64'(cap_rdy), 64'(1 << (k % N)));
            end
            if (k >= LAT) begin
                chk("rot_rsp_valid", 64'(cap_rv), 64'd1);
                chk("rot_rsp_id", 64'(cap_rid), 64'((k - LAT) % N));
            end
        end

        // backpressure: results must hold while the consumer stalls
        rnd_ops();
        cycle(4'hF, 1'b1);
        for (int s = 0; s < LAT + 3; s++) begin
            cycle(4'hF, 1'b0);
            if (s == LAT - 1) begin
                hold_d  = cap_rd;
                hold_id = cap_rid;
                chk("stall_first_id", 64'(cap_rid), 64'd0);
            end
            if (s >= LAT) begin
                chk("stall_valid", 64'(cap_rv), 64'd1);
                chk("stall_req_ready", 64'(cap_rdy), 64'd0);
                chk("stall_data", cap_rd, hold_d);
                chk("stall_id", 64'(cap_rid), 64'(hold_id));
            end
        end
        for (int s = 0; s < 6; s++) begin
            rnd_ops();
            cycle(4'hF, 1'b1);
        end
        repeat (LAT + 1) cycle('0, 1'b1);

        // asynchronous reset with results in flight
        rnd_ops();
        cycle(4'hF, 1'b1);
        cycle(4'hF, 1'b1);
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_data", rsp_data, 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(4'hF, 1'b1);
        chk("post_rst_grant", 64'(cap_rdy), 64'd1);
        repeat (LAT + 1) cycle('0, 1'b1);

        // randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            rnd_ops();
            cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        repeat (LAT + 2) cycle('0, 1'b1);
        chk("drain_empty", 64'(rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
